// File: rtl/ad7656_cfg_seq.sv
// Control-word sequencer upstream of the AD7656 parallel write driver: power-up
// default write, request queuing (one deep), bus handshake, settle and timeout.
module ad7656_cfg_seq #(
  parameter int unsigned PWRUP_CYCLES   = 1000,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  DEFAULT_CFG    = 8'h00
) (
  input  logic       sys_clk_i,
  input  logic       rst_i,
  input  logic       cfg_start_i,
  input  logic [7:0] cfg_word_i,
  input  logic       bus_busy_i,
  output logic       wr_flag_o,
  output logic [7:0] wr_data_o,
  output logic       cfg_busy_o,
  output logic       cfg_done_o,
  output logic       cfg_err_o,
  output logic [7:0] cfg_cur_o
);

  localparam int unsigned MAX_PS     = (PWRUP_CYCLES > SETTLE_CYCLES) ? PWRUP_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_PS > TIMEOUT_CYCLES) ? MAX_PS : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // The cycle in which BUSY first sees the bus idle already counts as settle time.
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_BUSY,
    S_SETTLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic [7:0]       pend_word;
  logic [7:0]       word;

  // A fresh request beats the held one; both are consumed on entry to ISSUE.
  logic       req_any;
  logic [7:0] req_word;
  assign req_any  = cfg_start_i | pending;
  assign req_word = cfg_start_i ? cfg_word_i : pend_word;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state      <= S_PWRUP;
      cnt        <= '0;
      pending    <= 1'b0;
      pend_word  <= 8'h00;
      word       <= 8'h00;
      wr_flag_o  <= 1'b0;
      wr_data_o  <= 8'h00;
      cfg_busy_o <= 1'b1;
      cfg_done_o <= 1'b0;
      cfg_err_o  <= 1'b0;
      cfg_cur_o  <= 8'h00;
    end else begin
      // NOTE: defaults first, case arms below override them; with non-blocking
      // assignments the last one written in the block is the one that lands.
      wr_flag_o  <= 1'b0;
      cfg_done_o <= 1'b0;
      if (cnt != '1) cnt <= cnt + 1'b1;

      if (cfg_start_i && state != S_IDLE) begin
        pending   <= 1'b1;
        pend_word <= cfg_word_i;
      end

      case (state)
        S_PWRUP: begin
          if (cnt == PWRUP_LAST) begin
            state      <= S_ISSUE;
            cnt        <= '0;
            pending    <= 1'b0;
            word       <= req_any ? req_word : DEFAULT_CFG;
            wr_data_o  <= req_any ? req_word : DEFAULT_CFG;
            wr_flag_o  <= 1'b1;
            cfg_err_o  <= 1'b0;
          end
        end

        S_IDLE: begin
          if (req_any) begin
            state      <= S_ISSUE;
            cnt        <= '0;
            pending    <= 1'b0;
            word       <= req_word;
            wr_data_o  <= req_word;
            wr_flag_o  <= 1'b1;
            cfg_err_o  <= 1'b0;
            cfg_busy_o <= 1'b1;
          end
        end

        S_ISSUE: begin
          state <= S_ACK;
          cnt   <= '0;
        end

        S_ACK: begin
          if (bus_busy_i) begin
            state <= S_BUSY;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cfg_err_o  <= 1'b1;
            cfg_busy_o <= 1'b0;
          end
        end

        S_BUSY: begin
          if (!bus_busy_i) begin
            cnt <= '0;
            if (SETTLE_CYCLES == 1) begin
              state      <= S_IDLE;
              cfg_done_o <= 1'b1;
              cfg_cur_o  <= word;
              cfg_busy_o <= 1'b0;
            end else begin
              state <= S_SETTLE;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cfg_err_o  <= 1'b1;
            cfg_busy_o <= 1'b0;
          end
        end

        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cfg_done_o <= 1'b1;
            cfg_cur_o  <= word;
            cfg_busy_o <= 1'b0;
          end
        end

        default: begin
          state      <= S_PWRUP;
          cnt        <= '0;
          cfg_busy_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad7656_cfg_seq.sv
// Directed bench for ad7656_cfg_seq with a behavioural model of the write driver
// (busy the cycle after the strobe, held four cycles).
module tb_ad7656_cfg_seq;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_start = 1'b0;
  logic [7:0] cfg_word = 8'h00;
  logic       bus_busy;
  logic       wr_flag;
  logic [7:0] wr_data;
  logic       cfg_busy;
  logic       cfg_done;
  logic       cfg_err;
  logic [7:0] cfg_cur;

  logic drv_en = 1'b1;
  logic force_busy = 1'b0;
  logic drv_busy;
  int   drv_left;

  int n_vec = 0;
  int n_err = 0;

  int         n_strobe = 0;
  int         n_done = 0;
  int         n_dbl = 0;
  int         n_busy_viol = 0;
  logic       prev_flag = 1'b0;
  logic [7:0] strobe_log [64];

  always #5 sys_clk = ~sys_clk;

  ad7656_cfg_seq #(
    .PWRUP_CYCLES  (16),
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(8),
    .DEFAULT_CFG   (8'hA5)
  ) dut (
    .sys_clk_i  (sys_clk),
    .rst_i      (rst),
    .cfg_start_i(cfg_start),
    .cfg_word_i (cfg_word),
    .bus_busy_i (bus_busy),
    .wr_flag_o  (wr_flag),
    .wr_data_o  (wr_data),
    .cfg_busy_o (cfg_busy),
    .cfg_done_o (cfg_done),
    .cfg_err_o  (cfg_err),
    .cfg_cur_o  (cfg_cur)
  );

  // Registered driver model: busy rises the cycle after the strobe, four cycles long.
  always @(posedge sys_clk) begin
    if (rst || !drv_en) begin
      drv_busy <= 1'b0;
      drv_left <= 0;
    end else if (wr_flag) begin
      drv_busy <= 1'b1;
      drv_left <= 3;
    end else if (drv_left != 0) begin
      drv_left <= drv_left - 1;
    end else begin
      drv_busy <= 1'b0;
    end
  end

  assign bus_busy = drv_en ? drv_busy : force_busy;

  always @(negedge sys_clk) begin
    if (wr_flag) begin
      strobe_log[n_strobe % 64] <= wr_data;
      n_strobe <= n_strobe + 1;
    end
    if (cfg_done) n_done <= n_done + 1;
    if (wr_flag && prev_flag) n_dbl <= n_dbl + 1;
    if (wr_flag && bus_busy && drv_en) n_busy_viol <= n_busy_viol + 1;
    prev_flag <= wr_flag;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse so it is sampled at the next edge; returns just after it.
  task automatic request(input logic [7:0] w);
    cfg_start = 1'b1;
    cfg_word  = w;
    tick(1);
    cfg_start = 1'b0;
  endtask

  int base_s;
  int base_d;

  initial begin
    // Reset state
    tick(2);
    check("rst_wr_flag", wr_flag, 1'b0);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_cfg_busy", cfg_busy, 1'b1);
    check("rst_cfg_done", cfg_done, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_cfg_cur", cfg_cur, 8'h00);
    rst = 1'b0;

    // Power-up default write: strobe in cycle 17, done in cycle 26
    tick(15);
    check("pwrup_no_early_strobe", wr_flag, 1'b0);
    tick(1);
    check("pwrup_strobe", wr_flag, 1'b1);
    check("pwrup_data", wr_data, 8'hA5);
    tick(8);
    check("pwrup_no_early_done", cfg_done, 1'b0);
    tick(1);
    check("pwrup_done", cfg_done, 1'b1);
    check("pwrup_cur", cfg_cur, 8'hA5);
    check("pwrup_idle", cfg_busy, 1'b0);
    tick(1);
    check("pwrup_done_single", cfg_done, 1'b0);

    // Single request from IDLE
    request(8'h3C);
    check("w3c_strobe", wr_flag, 1'b1);
    check("w3c_data", wr_data, 8'h3C);
    check("w3c_busy", cfg_busy, 1'b1);
    tick(1);
    check("w3c_strobe_single", wr_flag, 1'b0);
    tick(7);
    check("w3c_no_early_done", cfg_done, 1'b0);
    tick(1);
    check("w3c_done", cfg_done, 1'b1);
    check("w3c_cur", cfg_cur, 8'h3C);
    check("w3c_err", cfg_err, 1'b0);
    tick(2);

    // Two requests during BUSY: latest wins, issued right after the first done
    base_s = n_strobe;
    base_d = n_done;
    request(8'h11);
    check("pend_strobe_11", wr_data, 8'h11);
    tick(2);
    request(8'h22);
    cfg_start = 1'b1;
    cfg_word  = 8'h33;
    tick(1);
    cfg_start = 1'b0;
    tick(5);
    check("pend_done_11", cfg_done, 1'b1);
    check("pend_cur_11", cfg_cur, 8'h11);
    tick(1);
    check("pend_strobe_33", wr_flag, 1'b1);
    check("pend_data_33", wr_data, 8'h33);
    tick(9);
    check("pend_done_33", cfg_done, 1'b1);
    check("pend_cur_33", cfg_cur, 8'h33);
    tick(3);
    check("pend_strobe_count", n_strobe - base_s, 2);
    check("pend_done_count", n_done - base_d, 2);
    check("pend_log_0", strobe_log[base_s % 64], 8'h11);
    check("pend_log_1", strobe_log[(base_s + 1) % 64], 8'h33);

    // ACK timeout: bus never goes busy
    drv_en = 1'b0;
    base_d = n_done;
    request(8'h77);
    check("ack_to_strobe", wr_flag, 1'b1);
    tick(8);
    check("ack_to_no_early_err", cfg_err, 1'b0);
    tick(1);
    check("ack_to_err", cfg_err, 1'b1);
    check("ack_to_idle", cfg_busy, 1'b0);
    check("ack_to_cur_kept", cfg_cur, 8'h33);
    check("ack_to_no_done", n_done - base_d, 0);
    tick(2);

    // Good write afterwards clears the error at its strobe
    drv_en = 1'b1;
    request(8'h44);
    check("recover_err_cleared", cfg_err, 1'b0);
    check("recover_strobe", wr_flag, 1'b1);
    tick(9);
    check("recover_done", cfg_done, 1'b1);
    check("recover_cur", cfg_cur, 8'h44);
    tick(2);

    // BUSY timeout: bus stuck high after the strobe
    drv_en = 1'b0;
    base_d = n_done;
    request(8'h66);
    tick(1);
    force_busy = 1'b1;
    tick(8);
    check("busy_to_no_early_err", cfg_err, 1'b0);
    tick(1);
    check("busy_to_err", cfg_err, 1'b1);
    check("busy_to_cur_kept", cfg_cur, 8'h44);
    check("busy_to_idle", cfg_busy, 1'b0);
    request(8'h99);
    check("stuck_next_strobe", wr_data, 8'h99);
    check("stuck_next_err_cleared", cfg_err, 1'b0);
    tick(9);
    check("stuck_next_no_early_err", cfg_err, 1'b0);
    tick(1);
    check("stuck_next_err", cfg_err, 1'b1);
    check("stuck_next_cur_kept", cfg_cur, 8'h44);
    check("stuck_no_done", n_done - base_d, 0);
    force_busy = 1'b0;
    drv_en = 1'b1;
    tick(2);

    // Reset during BUSY with a pending request
    base_s = n_strobe;
    request(8'hAB);
    tick(2);
    request(8'hCD);
    rst = 1'b1;
    tick(1);
    check("midrst_wr_flag", wr_flag, 1'b0);
    check("midrst_wr_data", wr_data, 8'h00);
    check("midrst_cfg_busy", cfg_busy, 1'b1);
    check("midrst_cfg_err", cfg_err, 1'b0);
    check("midrst_cfg_cur", cfg_cur, 8'h00);
    rst = 1'b0;
    tick(15);
    check("midrst_no_early_strobe", wr_flag, 1'b0);
    tick(1);
    check("midrst_default_strobe", wr_flag, 1'b1);
    check("midrst_default_data", wr_data, 8'hA5);
    tick(9);
    check("midrst_done", cfg_done, 1'b1);
    check("midrst_cur", cfg_cur, 8'hA5);
    tick(20);
    check("midrst_strobe_count", n_strobe - base_s, 2);
    check("midrst_log_default", strobe_log[(base_s + 1) % 64], 8'hA5);

    // Strobe invariants across the whole run
    check("no_back_to_back_strobe", n_dbl, 0);
    check("no_strobe_while_busy", n_busy_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ad7656_cfg_seq.md
# ad7656_cfg_seq

Control-word sequencer that sits directly upstream of the AD7656 parallel write driver. After reset it waits a power-up delay, writes a default control word, then accepts further control-word requests from system logic. It handshakes on the driver's bus-busy flag, enforces a post-write settle time, and reports completion or a bus timeout. One 8-bit word is written per request; at most one request is held pending.

## Interface
- PWRUP_CYCLES, 1000: sys_clk_i cycles between reset release and the first (default) write; ≥1.
- SETTLE_CYCLES, 4: cycles waited after bus_busy_i falls before completion is reported; ≥1.
- TIMEOUT_CYCLES, 64: maximum cycles allowed in each bus wait phase; ≥1.
- DEFAULT_CFG, 8'h00: control word written automatically after power-up.

Ports:
- sys_clk_i  in  1  system clock (100 MHz)
- rst_i  in  1  synchronous, active-high reset
- cfg_start_i  in  1  single-cycle request to write cfg_word_i
- cfg_word_i  in  8  control word; sampled when cfg_start_i=1
- bus_busy_i  in  1  driver busy flag
- wr_flag_o  out  1  single-cycle write strobe to the driver
- wr_data_o  out  8  word presented to the driver; valid while wr_flag_o=1, held afterwards
- cfg_busy_o  out  1  high whenever state ≠ IDLE
- cfg_done_o  out  1  single-cycle pulse: write plus settle complete
- cfg_err_o  out  1  level: last write timed out
- cfg_cur_o  out  8  last successfully completed control word

## Operation
- One clock; reset is synchronous and active-high. All outputs are registered.
- States: PWRUP, IDLE, ISSUE, ACK, BUSY, SETTLE.
- PWRUP: counts PWRUP_CYCLES, then → ISSUE with DEFAULT_CFG, or with the pending word if a request arrived during PWRUP (the default write is skipped).
- IDLE: cfg_start_i=1 or pending set → ISSUE. A fresh cfg_start_i takes priority over pending; pending is cleared on entry to ISSUE.
- ISSUE: lasts 1 cycle. wr_flag_o=1, wr_data_o=word, cfg_err_o cleared → ACK.
- ACK: waits for bus_busy_i=1 → BUSY. After TIMEOUT_CYCLES cycles without it → IDLE with cfg_err_o=1.
- BUSY: waits for bus_busy_i=0 → SETTLE. After TIMEOUT_CYCLES cycles → IDLE with cfg_err_o=1.
- SETTLE: counts SETTLE_CYCLES cycles, then → IDLE. In that same cycle cfg_done_o=1 and cfg_cur_o=word.
- A timeout never pulses cfg_done_o and leaves cfg_cur_o unchanged.
- cfg_start_i in any state other than IDLE sets pending and stores cfg_word_i. A later request overwrites it (latest wins; one deep).
- Counters are sized $clog2(max(PWRUP_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES)+1), are zeroed on every state entry, and never wrap.
- Reset values: state PWRUP, wr_flag_o 0, wr_data_o 8'h00, cfg_busy_o 1, cfg_done_o 0, cfg_err_o 0, cfg_cur_o 8'h00, pending 0.
- Reset mid-write: everything returns to PWRUP at that edge and wr_flag_o drops immediately. The pending request is discarded, and the default write repeats after PWRUP_CYCLES.

## Timing
- The driver asserts busy the cycle after the strobe and holds it 4 cycles. With the driver attached:
  - cfg_start_i sampled at edge N (IDLE) → wr_flag_o high during cycle N+1.
  - bus_busy_i high during N+2..N+5.
  - SETTLE during N+6..N+5+SETTLE_CYCLES.
  - cfg_done_o pulses in cycle N+6+SETTLE_CYCLES, i.e. N+10 with the default.
- Back-to-back requests: the next wr_flag_o comes 1 cycle after cfg_done_o when pending is set.
- wr_flag_o is never high on two consecutive cycles, and never while bus_busy_i=1.

## Test plan
- Reset release, PWRUP_CYCLES=16, DEFAULT_CFG=8'hA5 → wr_flag_o at cycle 17 with wr_data_o=A5; cfg_done_o at cycle 26; cfg_cur_o=A5, cfg_busy_o=0.
- In IDLE, start with word 8'h3C → strobe at N+1, done at N+10, cfg_cur_o=3C, cfg_err_o=0.
- Start 8'h11 at IDLE, then starts 8'h22 and 8'h33 during BUSY → exactly two strobes (11, then 33), two done pulses, final cfg_cur_o=33.
- bus_busy_i tied 0, TIMEOUT_CYCLES=8 → no done pulse; cfg_err_o=1 at strobe+9; IDLE; cfg_cur_o unchanged. A subsequent good write clears cfg_err_o at its strobe.
- bus_busy_i stuck 1 after the strobe → cfg_err_o=1 after 8 BUSY cycles; the next request waits in ACK/BUSY per the same rule.
- rst_i pulsed during BUSY with a pending request → outputs at reset values the next cycle; one default write after PWRUP; the pending word is never written.
